intt_pass_sequencer: RTL and testbench



---
 rtl/intt_pass_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_intt_pass_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intt_pass_sequencer.sv
// Read/write/output schedule generator for the INTT core array: LOG_N passes of D=2^AW cycles each.
// Optional status outputs (pass_idx, run_count) are built when INTT_SEQ_STATUS_EN is defined.
module intt_pass_sequencer #(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 4,
  parameter int WR_LATENCY     = 8,
  parameter int OUT_LATENCY    = 12,
  localparam int AW = LOG_N - 2 - LOG_CORE_COUNT,
  localparam int LW = $clog2(LOG_N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    mode,
  output logic [LW-1:0] log_m,
  output logic [LW-1:0] log_t,
  output logic [AW:0]   upper_i,
  output logic [AW:0]   lower_i,
  output logic [AW-1:0] upper_addr,
  output logic [AW-1:0] lower_addr,
  output logic          input_select,
  output logic          read_select,
  output logic          wr_en_d,
  output logic          wr_sel_d,
  output logic          output_active,
  output logic [AW-1:0] out_addr
`ifdef INTT_SEQ_STATUS_EN
  ,
  output logic [LW-1:0] pass_idx,
  output logic [15:0]   run_count
`endif
);

  localparam int DW = $clog2(OUT_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [LW-1:0] pass_r, pass_s;
  logic [AW-1:0] cnt_r, cnt_s;
  logic [DW-1:0] drain_r, drain_s;

  logic [1:0]    mode_s;
  logic [LW-1:0] log_m_s, log_t_s, t_s;
  logic [AW-1:0] up_s, lo_s, tbit_s, low_mask_s, oaddr_raw_s;
  logic [AW:0]   up_i_s, lo_i_s;
  logic          in_sel_s, rd_sel_s, wr_raw_s, wsel_raw_s, oact_raw_s;

  logic                wr_raw_r, wsel_raw_r, oact_raw_r;
  logic [AW-1:0]       oaddr_raw_r;
  logic [WR_LATENCY-1:0]  wr_pipe_r, wsel_pipe_r;
  logic [OUT_LATENCY-1:0] oact_pipe_r;
  logic [AW-1:0]          oaddr_pipe_r [OUT_LATENCY];

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pass_r  <= {LW{1'b0}};
      cnt_r   <= {AW{1'b0}};
      drain_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      pass_r  <= pass_s;
      cnt_r   <= cnt_s;
      drain_r <= drain_s;
    end
  end

  // Next-state: passes back to back, then drain the output latency, then a one-step done
  always_comb begin
    state_s = state_r;
    pass_s  = pass_r;
    cnt_s   = cnt_r;
    drain_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
          pass_s  = {LW{1'b0}};
          cnt_s   = {AW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_s = cnt_r + AW'(1);
        if (cnt_r == {AW{1'b1}}) begin
          if (pass_r == LW'(LOG_N - 1)) begin
            state_s = ST_DRAIN;
            pass_s  = {LW{1'b0}};
            drain_s = {DW{1'b0}};
          end else begin
            pass_s = pass_r + LW'(1);
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DW'(OUT_LATENCY - 1)) begin
          state_s = ST_DONE;
        end else begin
          drain_s = drain_r + DW'(1);
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Per-cycle schedule; SECOND-stage addresses rotate the group field left by one bit
  always_comb begin
    mode_s      = 2'd3;
    log_m_s     = {LW{1'b0}};
    log_t_s     = {LW{1'b0}};
    up_s        = {AW{1'b0}};
    lo_s        = {AW{1'b0}};
    up_i_s      = {(AW+1){1'b0}};
    lo_i_s      = {(AW+1){1'b0}};
    in_sel_s    = 1'b0;
    rd_sel_s    = 1'b0;
    wr_raw_s    = 1'b0;
    wsel_raw_s  = 1'b0;
    oact_raw_s  = 1'b0;
    oaddr_raw_s = {AW{1'b0}};
    t_s         = pass_r - LW'(1);
    tbit_s      = AW'(1) << t_s;
    low_mask_s  = tbit_s - AW'(1);
    if (state_r == ST_RUN) begin
      log_m_s    = LW'(LOG_N) - pass_r;
      log_t_s    = t_s;
      wr_raw_s   = 1'b1;
      wsel_raw_s = pass_r[0];
      up_s       = cnt_r;
      lo_s       = cnt_r;
      if (pass_r == {LW{1'b0}}) begin
        mode_s   = 2'd0;
        in_sel_s = 1'b1;
      end else if (pass_r <= LW'(AW)) begin
        mode_s   = 2'd1;
        rd_sel_s = ~pass_r[0];
        up_s     = (cnt_r & low_mask_s)
                 | ((cnt_r << 1'b1) & ~(low_mask_s | tbit_s))
                 | (cnt_r[AW-1] ? tbit_s : {AW{1'b0}});
        lo_s     = up_s ^ tbit_s;
        up_i_s   = {1'b0, up_s} >> t_s;
        lo_i_s   = {1'b0, lo_s} >> t_s;
      end else begin
        mode_s   = 2'd2;
        rd_sel_s = ~pass_r[0];
      end
      if (pass_r == LW'(LOG_N - 1)) begin
        oact_raw_s  = 1'b1;
        oaddr_raw_s = up_s;
      end else begin
        oact_raw_s  = 1'b0;
      end
    end else begin
      mode_s = 2'd3;
    end
  end

  // Registered schedule outputs and raw strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode         <= 2'd3;
      log_m        <= {LW{1'b0}};
      log_t        <= {LW{1'b0}};
      upper_i      <= {(AW+1){1'b0}};
      lower_i      <= {(AW+1){1'b0}};
      upper_addr   <= {AW{1'b0}};
      lower_addr   <= {AW{1'b0}};
      input_select <= 1'b0;
      read_select  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_raw_r     <= 1'b0;
      wsel_raw_r   <= 1'b0;
      oact_raw_r   <= 1'b0;
      oaddr_raw_r  <= {AW{1'b0}};
    end else begin
      mode         <= mode_s;
      log_m        <= log_m_s;
      log_t        <= log_t_s;
      upper_i      <= up_i_s;
      lower_i      <= lo_i_s;
      upper_addr   <= up_s;
      lower_addr   <= lo_s;
      input_select <= in_sel_s;
      read_select  <= rd_sel_s;
      busy         <= (state_r == ST_RUN) || (state_r == ST_DRAIN);
      done         <= (state_r == ST_DONE);
      wr_raw_r     <= wr_raw_s;
      wsel_raw_r   <= wsel_raw_s;
      oact_raw_r   <= oact_raw_s;
      oaddr_raw_r  <= oaddr_raw_s;
    end
  end

  // Write and output-valid delay lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pipe_r   <= {WR_LATENCY{1'b0}};
      wsel_pipe_r <= {WR_LATENCY{1'b0}};
      oact_pipe_r <= {OUT_LATENCY{1'b0}};
      for (int k = 0; k < OUT_LATENCY; k++) oaddr_pipe_r[k] <= {AW{1'b0}};
    end else begin
      wr_pipe_r[0]    <= wr_raw_r;
      wsel_pipe_r[0]  <= wsel_raw_r;
      for (int k = 1; k < WR_LATENCY; k++) begin
        wr_pipe_r[k]   <= wr_pipe_r[k-1];
        wsel_pipe_r[k] <= wsel_pipe_r[k-1];
      end
      oact_pipe_r[0]  <= oact_raw_r;
      oaddr_pipe_r[0] <= oaddr_raw_r;
      for (int k = 1; k < OUT_LATENCY; k++) begin
        oact_pipe_r[k]  <= oact_pipe_r[k-1];
        oaddr_pipe_r[k] <= oaddr_pipe_r[k-1];
      end
    end
  end

  assign wr_en_d       = wr_pipe_r[WR_LATENCY-1];
  assign wr_sel_d      = wsel_pipe_r[WR_LATENCY-1];
  assign output_active = oact_pipe_r[OUT_LATENCY-1];
  assign out_addr      = oaddr_pipe_r[OUT_LATENCY-1];

`ifdef INTT_SEQ_STATUS_EN
  // Status: current pass and completed-run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_idx  <= {LW{1'b0}};
      run_count <= 16'd0;
    end else begin
      pass_idx <= (state_r == ST_RUN) ? pass_r : {LW{1'b0}};
      if (state_r == ST_DONE) begin
        run_count <= run_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_intt_pass_sequencer.sv
// Scoreboard bench: a pass-level model queues the expected schedule, a negedge monitor compares.
module tb_intt_pass_sequencer;
  localparam int LOG_N = 12, LCC = 4, WL = 8, OL = 12;
  localparam int AW  = LOG_N - 2 - LCC;
  localparam int D   = 1 << AW;
  localparam int LW  = $clog2(LOG_N + 1);
  localparam int TOT = LOG_N * D + OL;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic busy, done, input_select, read_select, wr_en_d, wr_sel_d, output_active;
  logic [1:0] mode;
  logic [LW-1:0] log_m, log_t;
  logic [AW:0] upper_i, lower_i;
  logic [AW-1:0] upper_addr, lower_addr, out_addr;
`ifdef INTT_SEQ_STATUS_EN
  logic [LW-1:0] pass_idx;
  logic [15:0] run_count;
`endif

  intt_pass_sequencer #(.LOG_N(LOG_N), .LOG_CORE_COUNT(LCC), .WR_LATENCY(WL), .OUT_LATENCY(OL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .mode(mode),
    .log_m(log_m), .log_t(log_t), .upper_i(upper_i), .lower_i(lower_i),
    .upper_addr(upper_addr), .lower_addr(lower_addr), .input_select(input_select),
    .read_select(read_select), .wr_en_d(wr_en_d), .wr_sel_d(wr_sel_d),
    .output_active(output_active), .out_addr(out_addr)
`ifdef INTT_SEQ_STATUS_EN
    , .pass_idx(pass_idx), .run_count(run_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int mode; int log_m; int log_t; int ua; int la; int ui; int li; int isel; int rsel; int p;
  } rd_t;
  typedef struct { int cyc; int val; } tv_t;

  rd_t rd_q[$];
  tv_t wr_q[$];
  tv_t out_q[$];
  int cyc = 0, e0 = -1, runs = 0;
  int checks = 0, failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Expected schedule of one run whose start is sampled at edge s0
  task automatic build_run(input int s0);
    for (int p = 0; p < LOG_N; p++) begin
      for (int k = 0; k < D; k++) begin
        rd_t r;
        r.cyc = s0 + 1 + p * D + k;
        r.p = p;
        r.log_m = LOG_N - p;
        r.log_t = (p - 1) & ((1 << LW) - 1);
        r.mode = (p == 0) ? 0 : (p <= AW) ? 1 : 2;
        r.isel = (p == 0) ? 1 : 0;
        r.rsel = (p == 0) ? 0 : (p - 1) % 2;
        r.ua = k; r.la = k; r.ui = 0; r.li = 0;
        if (r.mode == 1) begin
          int w, g, gs, j;
          w = 1 << (p - 1);
          g = D / w;
          gs = k / w;
          j = k % w;
          r.ui = (gs < g / 2) ? 2 * gs : 2 * (gs - g / 2) + 1;
          r.li = (gs < g / 2) ? 2 * gs + 1 : 2 * (gs - g / 2);
          r.ua = r.ui * w + j;
          r.la = r.li * w + j;
        end
        rd_q.push_back(r);
      end
    end
    for (int s = 0; s < LOG_N * D; s++) wr_q.push_back('{s0 + 1 + WL + s, (s / D) % 2});
    for (int k = 0; k < D; k++) out_q.push_back('{s0 + 1 + (LOG_N - 1) * D + OL + k, k});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, write or output strobe
  int n;
  bit exp_done;
  rd_t r;
  tv_t t;
  always @(negedge clk) begin
    if (rst_n) begin
      n = (e0 >= 0) ? cyc - e0 : -1;
      exp_done = (e0 >= 0) && (n == TOT + 1);
      chk("busy", busy, (e0 >= 0 && n >= 1 && n <= TOT) ? 1 : 0);
      chk("done", done, exp_done ? 1 : 0);
      if (exp_done) runs++;
`ifdef INTT_SEQ_STATUS_EN
      if (!exp_done) chk("run_count", run_count, runs);
`endif
      if (mode != 2'd3) begin
        if (rd_q.size() == 0) chk("spurious_mode", mode, 3);
        else begin
          r = rd_q.pop_front();
          chk("rd_cycle", cyc, r.cyc);
          chk("mode", mode, r.mode);
          chk("log_m", log_m, r.log_m);
          chk("log_t", log_t, r.log_t);
          chk("upper_addr", upper_addr, r.ua);
          chk("lower_addr", lower_addr, r.la);
          chk("input_select", input_select, r.isel);
          chk("read_select", read_select, r.rsel);
          if (r.mode == 1) begin
            chk("upper_i", upper_i, r.ui);
            chk("lower_i", lower_i, r.li);
          end
`ifdef INTT_SEQ_STATUS_EN
          chk("pass_idx", pass_idx, r.p);
`endif
        end
      end else begin
        if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
          chk("missing_read", mode, rd_q[0].mode);
          void'(rd_q.pop_front());
        end
        chk("standby_outs", (|{log_m, log_t, upper_i, lower_i, upper_addr, lower_addr,
                               input_select, read_select}) ? 1 : 0, 0);
`ifdef INTT_SEQ_STATUS_EN
        chk("standby_pass_idx", pass_idx, 0);
`endif
      end
      if (wr_en_d) begin
        if (wr_q.size() == 0) chk("spurious_wr_en", wr_en_d, 0);
        else begin
          t = wr_q.pop_front();
          chk("wr_cycle", cyc, t.cyc);
          chk("wr_sel_d", wr_sel_d, t.val);
        end
      end else begin
        if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
          chk("missing_wr_en", wr_en_d, 1);
          void'(wr_q.pop_front());
        end
        chk("wr_sel_idle", wr_sel_d, 0);
      end
      if (output_active) begin
        if (out_q.size() == 0) chk("spurious_output", output_active, 0);
        else begin
          t = out_q.pop_front();
          chk("out_cycle", cyc, t.cyc);
          chk("out_addr", out_addr, t.val);
        end
      end else begin
        if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
          chk("missing_output", output_active, 1);
          void'(out_q.pop_front());
        end
        chk("out_addr_idle", out_addr, 0);
      end
    end
  end

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) to_neg();
  endtask

  // Drive a one-cycle start pulse; the model alone decides whether it is accepted
  task automatic pulse_start();
    if (e0 < 0 || (cyc - e0) >= TOT + 1) begin
      e0 = cyc + 1;
      build_run(e0);
    end
    start = 1'b1;
    to_neg();
    start = 1'b0;
  endtask

  task automatic wait_until_rel(input int rel);
    while (cyc - e0 < rel) to_neg();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mode"}, mode, 3);
    chk({tag, "_busy_done"}, {busy, done}, 0);
    chk({tag, "_others"}, (|{log_m, log_t, upper_i, lower_i, upper_addr, lower_addr, input_select,
                            read_select, wr_en_d, wr_sel_d, output_active, out_addr}) ? 1 : 0, 0);
  endtask

  initial begin
    wait_cycles(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    wait_cycles(100);

    // Run 1 with ignored starts at cycles 10, 500 and a few random ones
    pulse_start();
    wait_until_rel(10);  pulse_start();
    repeat (3) begin
      wait_until_rel(cyc - e0 + $urandom_range(20, 100));
      pulse_start();
    end
    wait_until_rel(500); pulse_start();
    wait_until_rel(TOT + 1);
    pulse_start();  // restart in the done cycle

    // Run 2 with random ignored starts
    repeat (4) begin
      wait_until_rel(cyc - e0 + $urandom_range(50, 180));
      pulse_start();
    end
    wait_until_rel(TOT + 2);
    wait_cycles($urandom_range(5, 30));

    // Run 3 aborted by reset at cycle 300
    pulse_start();
    wait_until_rel(300);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    rd_q.delete(); wr_q.delete(); out_q.delete();
    e0 = -1;
    runs = 0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(60);

    // Run 4 after a random idle gap
    wait_cycles($urandom_range(1, 40));
    pulse_start();
    wait_until_rel(TOT + 6);

    chk("rd_q_left", rd_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
